sw_debounce: RTL and testbench



---
 rtl/sw_debounce_pkg.sv | 21 ++
 rtl/sw_debounce_bit.sv | 56 +++++
 rtl/sw_debounce.sv | 83 ++++++++
 tb/tb_sw_debounce.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// ============================================================================
// Module : sw_debounce_pkg
// Brief  : Shared constants and types for the slide-switch debouncer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sw_debounce_pkg;

    // 20 ms settle time at a 50 MHz clock
    localparam int DEFAULT_STABLE_CYCLES = 1_000_000;
    localparam int SIM_STABLE_CYCLES     = 4;

    typedef enum logic {
        ST_MATCH    = 1'b0,
        ST_MISMATCH = 1'b1
    } db_state_t;

endpackage

`default_nettype wire

// File: rtl/sw_debounce_bit.sv
// ============================================================================
// Module : debounce_bit
// Brief  : Two-flop synchroniser, stability counter and stable flop for one bit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_WIDTH     = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic stable_o,
    output logic upd_o
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_stable;
    logic [CNT_WIDTH-1:0] r_cnt;
    db_state_t            w_state;

    assign w_state  = (r_sync2 != r_stable) ? ST_MISMATCH : ST_MATCH;
    // High on the edge that will flip the stable value
    assign upd_o    = (w_state == ST_MISMATCH) && (r_cnt == C_CNT_MAX);
    assign stable_o = r_stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
            if (w_state == ST_MATCH) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_MAX) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sw_debounce.sv
// ============================================================================
// Module : sw_debounce
// Brief  : Per-bit switch debouncer with sticky valid/rd handshake.
//          SW_DEBOUNCE_EDGE_EN adds rise/fall edge-pulse outputs.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      sw,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  valid,
    output logic                  changed
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0]      rise,
    output logic [WIDTH-1:0]      fall
`endif
);

    localparam int CNT_WIDTH = $clog2(STABLE_CYCLES);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_upd;
    logic             w_any_upd;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_WIDTH     (CNT_WIDTH)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .sw       (sw[i]),
            .stable_o (w_stable[i]),
            .upd_o    (w_upd[i])
        );
    end

    assign w_any_upd = |w_upd;
    assign out       = DATA_WIDTH'(w_stable);

    // New data wins over a simultaneous read acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            changed <= 1'b0;
        end else begin
            changed <= w_any_upd;
            if (w_any_upd) begin
                valid <= 1'b1;
            end else if (rd) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    // An update always inverts the bit, so the old value gives the direction
    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= w_upd & ~w_stable;
            fall <= w_upd &  w_stable;
        end
    end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_sw_debounce.sv
// ============================================================================
// Module : tb_sw_debounce
// Brief  : Directed scoreboard bench for sw_debounce (STABLE_CYCLES = 4).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sw_debounce;
    import sw_debounce_pkg::*;

    localparam int W  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd;
    logic [W-1:0]  sw;
    logic [DW-1:0] out;
    logic          valid;
    logic          changed;
`ifdef SW_DEBOUNCE_EDGE_EN
    logic [W-1:0]  rise;
    logic [W-1:0]  fall;
`endif

    int n_checks  = 0;
    int n_pass    = 0;
    int n_changed = 0;
    int c0;
    logic [DW-1:0] exp_q[$];

    sw_debounce #(
        .WIDTH         (W),
        .DATA_WIDTH    (DW),
        .STABLE_CYCLES (SIM_STABLE_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .rd      (rd),
        .out     (out),
        .valid   (valid),
        .changed (changed)
`ifdef SW_DEBOUNCE_EDGE_EN
        ,
        .rise    (rise),
        .fall    (fall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every changed pulse must match the next queued expected word
    always @(negedge clk) begin
        if (rst === 1'b0 && changed === 1'b1) begin
            n_changed++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_changed", 32'(exp_q.size()), 32'd1);
            end else begin
                check("sb_out", 32'(out), 32'(exp_q.pop_front()));
                check("sb_valid", 32'(valid), 32'd1);
            end
        end
    end

    initial begin
        rst = 1'b1;
        rd  = 1'b0;
        sw  = 4'hF;
        step(3);
        check("reset_out", 32'(out), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_changed", 32'(changed), 32'h0);
`ifdef SW_DEBOUNCE_EDGE_EN
        check("reset_rise", 32'(rise), 32'h0);
        check("reset_fall", 32'(fall), 32'h0);
`endif

        // Release reset with all switches high: update 5 edges later
        exp_q.push_back(16'h000F);
        rst = 1'b0;
        step(5);
        check("rel_early_out", 32'(out), 32'h0);
        check("rel_early_changed", 32'(changed), 32'h0);
        step(1);
        check("rel_out", 32'(out), 32'h000F);
        check("rel_changed", 32'(changed), 32'h1);
        check("rel_valid", 32'(valid), 32'h1);
        step(1);
        check("rel_changed_pulse", 32'(changed), 32'h0);
        check("rel_valid_sticky", 32'(valid), 32'h1);
        rd = 1'b1; step(1); rd = 1'b0;
        check("rel_rd_clear", 32'(valid), 32'h0);

        // All switches low again
        exp_q.push_back(16'h0000);
        sw = 4'h0;
        step(5);
        check("fall_early_out", 32'(out), 32'h000F);
        step(1);
        check("fall_out", 32'(out), 32'h0);
        check("fall_changed", 32'(changed), 32'h1);
`ifdef SW_DEBOUNCE_EDGE_EN
        check("fall_fall", 32'(fall), 32'hF);
        check("fall_rise", 32'(rise), 32'h0);
`endif
        rd = 1'b1; step(1); rd = 1'b0;

        // sw[2] rises and holds
        exp_q.push_back(16'h0004);
        sw = 4'b0100;
        step(5);
        check("b2_early_out", 32'(out), 32'h0);
        step(1);
        check("b2_out", 32'(out), 32'h0004);
        check("b2_changed", 32'(changed), 32'h1);
        step(3);
        check("b2_valid_held", 32'(valid), 32'h1);
        check("b2_changed_low", 32'(changed), 32'h0);
        rd = 1'b1; step(1); rd = 1'b0;
        check("b2_rd_clear", 32'(valid), 32'h0);

        // Glitch on sw[0] lasting STABLE_CYCLES-1 must be rejected
        c0 = n_changed;
        sw = 4'b0101;
        step(3);
        sw = 4'b0100;
        step(10);
        check("glitch_out", 32'(out), 32'h0004);
        check("glitch_valid", 32'(valid), 32'h0);
        check("glitch_no_changed", 32'(n_changed), 32'(c0));

        // Back to zero, then two bits together
        exp_q.push_back(16'h0000);
        sw = 4'h0;
        step(6);
        rd = 1'b1; step(1); rd = 1'b0;
        c0 = n_changed;
        exp_q.push_back(16'h000A);
        sw = 4'b1010;
        step(5);
        check("pair_early_out", 32'(out), 32'h0);
        step(1);
        check("pair_out", 32'(out), 32'h000A);
        check("pair_changed", 32'(changed), 32'h1);
        step(6);
        check("pair_single_pulse", 32'(n_changed), 32'(c0 + 1));
        rd = 1'b1; step(1); rd = 1'b0;
        check("pair_rd_clear", 32'(valid), 32'h0);

        // rd on the same edge as an update: valid stays set
        exp_q.push_back(16'h0000);
        sw = 4'h0;
        step(5);
        check("rdupd_pre_valid", 32'(valid), 32'h0);
        rd = 1'b1; step(1); rd = 1'b0;
        check("rdupd_valid", 32'(valid), 32'h1);
        check("rdupd_out", 32'(out), 32'h0);
        step(1);
        check("rdupd_valid_hold", 32'(valid), 32'h1);
        rd = 1'b1; step(1); rd = 1'b0;
        check("rdupd_next_rd", 32'(valid), 32'h0);

        // Reset mid-count discards the partial count
        sw = 4'b0010;
        step(5);
        check("midrst_pre_out", 32'(out), 32'h0);
        rst = 1'b1; step(1);
        check("midrst_out", 32'(out), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        check("midrst_changed", 32'(changed), 32'h0);
        exp_q.push_back(16'h0002);
        rst = 1'b0;
        step(5);
        check("midrst_restart_out", 32'(out), 32'h0);
        check("midrst_restart_changed", 32'(changed), 32'h0);
        step(1);
        check("midrst_final_out", 32'(out), 32'h0002);
        check("midrst_final_changed", 32'(changed), 32'h1);
`ifdef SW_DEBOUNCE_EDGE_EN
        check("rise_b1", 32'(rise), 32'h2);
        check("fall_none", 32'(fall), 32'h0);
`endif
        step(1);
        check("midrst_changed_low", 32'(changed), 32'h0);
`ifdef SW_DEBOUNCE_EDGE_EN
        check("rise_pulse_end", 32'(rise), 32'h0);
`endif

        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
